// File: rtl/veresk485_pkg.sv
// ---------------------------------------------------------------------------
// veresk485_pkg
// Shared definitions for the RS-485 transaction controller:
//   - trn_state_t : transaction FSM state encoding
//   - TRN_*       : per-transaction result codes reported on p_out_result
//   - ST_*        : status codes driven by the Manchester master
//   - trn_result  : result-code priority encoder
// ---------------------------------------------------------------------------
package veresk485_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TX   = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } trn_state_t;

  localparam logic [2:0] TRN_OK      = 3'd0;
  localparam logic [2:0] TRN_PARITY  = 3'd1;
  localparam logic [2:0] TRN_TIMEOUT = 3'd2;
  localparam logic [2:0] TRN_HDR     = 3'd3;
  localparam logic [2:0] TRN_OVF     = 3'd4;
  localparam logic [2:0] TRN_SHORT   = 3'd5;

  localparam logic [2:0] ST_RX_OK    = 3'd1;
  localparam logic [2:0] ST_RX_ERR   = 3'd2;

  // Result priority, high to low: timeout, parity, short answer,
  // header mismatch, payload overflow, ok.
  function automatic logic [2:0] trn_result(input logic tmo,
                                            input logic parity,
                                            input logic short_rx,
                                            input logic hdr,
                                            input logic ovf);
    logic [2:0] res;
    if (tmo)           res = TRN_TIMEOUT;
    else if (parity)   res = TRN_PARITY;
    else if (short_rx) res = TRN_SHORT;
    else if (hdr)      res = TRN_HDR;
    else if (ovf)      res = TRN_OVF;
    else               res = TRN_OK;
    return res;
  endfunction

endpackage

// File: rtl/veresk485_bytebuf.sv
// ---------------------------------------------------------------------------
// veresk485_bytebuf
// Simple dual-port byte RAM, 2**AW entries x 8 bit.
//   clk, rst : clock, asynchronous active-high reset (read register only)
//   wr_en    : write strobe, synchronous write of wr_d to wr_adr
//   rd_adr   : read address
//   rd_q     : registered read data, 1-cycle latency
// The array itself is not reset; contents are undefined after reset.
// ---------------------------------------------------------------------------
module veresk485_bytebuf #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_adr,
  input  logic [7:0]    wr_d,
  input  logic [AW-1:0] rd_adr,
  output logic [7:0]    rd_q
);

  logic [7:0] mem [2**AW];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_adr] <= wr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[rd_adr];
    end
  end

  assign rd_q = rd_data_q;

endmodule

// File: rtl/veresk485_trn.sv
// ---------------------------------------------------------------------------
// veresk485_trn
// Transaction controller in front of the RS-485 Manchester master.
// A host start (p_in_req) latches address, command and payload length,
// the header and payload are streamed to the master byte by byte, then the
// answer is collected: echoed header checked, payload stored in the RX
// buffer, timeout enforced, and one result code reported with p_out_done.
//
// Ports:
//   p_in_clk, p_in_rst           : clock, asynchronous active-high reset
//   p_in_req                     : start pulse (ignored while busy)
//   p_in_dev_adr/dev_cmd/txlen   : request header and payload length
//   p_in_txbuf_wr/adr/d          : TX payload buffer write (idle only)
//   p_in_rxbuf_adr, p_out_rxbuf_q: RX payload buffer read, 1-cycle latency
//   p_out_rxlen                  : number of received payload bytes stored
//   p_out_busy/done/result       : transaction status to the host
//   p_out_txd_rdy/txd, p_in_txd_rd        : byte stream to the master
//   p_in_rxd, p_in_rxd_wr, p_in_status    : answer stream from the master
//
// Master handshake: p_out_txd is valid and held stable while p_out_txd_rdy
// is high; a one-cycle p_in_txd_rd consumes it and the next byte appears on
// the following cycle. Each p_in_rxd_wr pulse delivers one answer byte;
// a nonzero p_in_status ends the answer phase.
// ---------------------------------------------------------------------------
module veresk485_trn
  import veresk485_pkg::*;
#(
  parameter int G_BUF_AW = 4,
  parameter int G_TMO    = 32000,
  parameter int G_TMO_W  = 16
) (
  input  logic                p_in_clk,
  input  logic                p_in_rst,
  input  logic                p_in_req,
  input  logic [7:0]          p_in_dev_adr,
  input  logic [7:0]          p_in_dev_cmd,
  input  logic [G_BUF_AW:0]   p_in_txlen,
  input  logic                p_in_txbuf_wr,
  input  logic [G_BUF_AW-1:0] p_in_txbuf_adr,
  input  logic [7:0]          p_in_txbuf_d,
  input  logic [G_BUF_AW-1:0] p_in_rxbuf_adr,
  output logic [7:0]          p_out_rxbuf_q,
  output logic [G_BUF_AW:0]   p_out_rxlen,
  output logic                p_out_busy,
  output logic                p_out_done,
  output logic [2:0]          p_out_result,
  output logic                p_out_txd_rdy,
  output logic [7:0]          p_out_txd,
  input  logic                p_in_txd_rd,
  input  logic [7:0]          p_in_rxd,
  input  logic                p_in_rxd_wr,
  input  logic [2:0]          p_in_status
);

  localparam int D  = 2**G_BUF_AW;
  localparam int LW = G_BUF_AW + 1;   // length width, holds 0..D
  localparam int IW = G_BUF_AW + 2;   // index/count width, holds beyond D+1

  localparam logic [LW-1:0]      D_LEN    = LW'(D);
  localparam logic [IW-1:0]      D_IDX    = IW'(D);
  localparam logic [IW-1:0]      CNT_MAX  = '1;
  localparam logic [G_TMO_W-1:0] TMO_LAST = G_TMO_W'(G_TMO - 1);

  trn_state_t         state_q,   state_d;
  logic [7:0]         adr_q,     adr_d;
  logic [7:0]         cmd_q,     cmd_d;
  logic [LW-1:0]      len_q,     len_d;
  logic [IW-1:0]      tx_idx_q,  tx_idx_d;
  logic [IW-1:0]      rx_cnt_q,  rx_cnt_d;
  logic               hdr_err_q, hdr_err_d;
  logic               ovf_q,     ovf_d;
  logic [G_TMO_W-1:0] tmo_q,     tmo_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic               txd_rdy_q, txd_rdy_d;
  logic [2:0]         result_q,  result_d;
  logic [LW-1:0]      rxlen_q,   rxlen_d;

  // Answer-byte effects for the current cycle, evaluated before status.
  logic               hdr_n;
  logic               ovf_n;
  logic [IW-1:0]      cnt_n;
  logic [IW-1:0]      pay_idx;

  logic                rx_wr_en;
  logic [G_BUF_AW-1:0] rx_wr_adr;
  logic                tx_wr_en;
  logic [G_BUF_AW-1:0] tx_rd_adr;
  logic [7:0]          txbuf_q;

  // Host may only load the TX buffer between transactions.
  assign tx_wr_en = p_in_txbuf_wr && (state_q == S_IDLE);

  // The TX RAM has registered read, so it is addressed with the *next*
  // index: the payload byte is then ready the cycle tx_idx_q reaches it.
  assign tx_rd_adr = G_BUF_AW'(tx_idx_d - IW'(2));

  veresk485_bytebuf #(.AW(G_BUF_AW)) u_txbuf (
    .clk    (p_in_clk),
    .rst    (p_in_rst),
    .wr_en  (tx_wr_en),
    .wr_adr (p_in_txbuf_adr),
    .wr_d   (p_in_txbuf_d),
    .rd_adr (tx_rd_adr),
    .rd_q   (txbuf_q)
  );

  veresk485_bytebuf #(.AW(G_BUF_AW)) u_rxbuf (
    .clk    (p_in_clk),
    .rst    (p_in_rst),
    .wr_en  (rx_wr_en),
    .wr_adr (rx_wr_adr),
    .wr_d   (p_in_rxd),
    .rd_adr (p_in_rxbuf_adr),
    .rd_q   (p_out_rxbuf_q)
  );

  always_ff @(posedge p_in_clk or posedge p_in_rst) begin
    if (p_in_rst) begin
      state_q   <= S_IDLE;
      adr_q     <= '0;
      cmd_q     <= '0;
      len_q     <= '0;
      tx_idx_q  <= '0;
      rx_cnt_q  <= '0;
      hdr_err_q <= 1'b0;
      ovf_q     <= 1'b0;
      tmo_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      txd_rdy_q <= 1'b0;
      result_q  <= '0;
      rxlen_q   <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      tx_idx_q  <= tx_idx_d;
      rx_cnt_q  <= rx_cnt_d;
      hdr_err_q <= hdr_err_d;
      ovf_q     <= ovf_d;
      tmo_q     <= tmo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      txd_rdy_q <= txd_rdy_d;
      result_q  <= result_d;
      rxlen_q   <= rxlen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    tx_idx_d  = tx_idx_q;
    rx_cnt_d  = rx_cnt_q;
    hdr_err_d = hdr_err_q;
    ovf_d     = ovf_q;
    tmo_d     = tmo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    txd_rdy_d = txd_rdy_q;
    result_d  = result_q;
    rxlen_d   = rxlen_q;
    hdr_n     = hdr_err_q;
    ovf_n     = ovf_q;
    cnt_n     = rx_cnt_q;
    pay_idx   = rx_cnt_q - IW'(2);
    rx_wr_en  = 1'b0;
    rx_wr_adr = '0;

    case (state_q)
      S_IDLE: begin
        if (p_in_req) begin
          adr_d     = p_in_dev_adr;
          cmd_d     = p_in_dev_cmd;
          len_d     = (p_in_txlen > D_LEN) ? D_LEN : p_in_txlen;
          tx_idx_d  = '0;
          rx_cnt_d  = '0;
          hdr_err_d = 1'b0;
          ovf_d     = 1'b0;
          rxlen_d   = '0;
          busy_d    = 1'b1;
          txd_rdy_d = 1'b1;
          state_d   = S_TX;
        end
      end

      S_TX: begin
        if (p_in_txd_rd) begin
          tx_idx_d = tx_idx_q + IW'(1);
          // Byte index len+1 is the last payload byte (header is 0 and 1).
          // Dropping txd_rdy on the next cycle keeps it ahead of the
          // master's end-of-byte check.
          if (tx_idx_q == ({1'b0, len_q} + IW'(1))) begin
            txd_rdy_d = 1'b0;
            tmo_d     = '0;
            state_d   = S_RESP;
          end
        end
      end

      S_RESP: begin
        if (p_in_rxd_wr) begin
          tmo_d = '0;
          if (rx_cnt_q != CNT_MAX) begin
            cnt_n = rx_cnt_q + IW'(1);
          end
          if (rx_cnt_q == IW'(0)) begin
            hdr_n = hdr_err_q | (p_in_rxd != adr_q);
          end else if (rx_cnt_q == IW'(1)) begin
            hdr_n = hdr_err_q | (p_in_rxd != cmd_q);
          end else if (pay_idx < D_IDX) begin
            rx_wr_en  = 1'b1;
            rx_wr_adr = G_BUF_AW'(pay_idx);
            rxlen_d   = LW'(pay_idx + IW'(1));
          end else begin
            // Payload beyond the buffer is dropped, never wrapped.
            ovf_n = 1'b1;
          end
        end else begin
          tmo_d = tmo_q + G_TMO_W'(1);
        end
        rx_cnt_d  = cnt_n;
        hdr_err_d = hdr_n;
        ovf_d     = ovf_n;

        // Status is judged against the byte counts including this cycle's
        // byte, so a byte arriving with the status strobe still counts.
        if (p_in_status != 3'd0) begin
          done_d   = 1'b1;
          result_d = trn_result(1'b0, (p_in_status == ST_RX_ERR),
                                (cnt_n < IW'(2)), hdr_n, ovf_n);
          state_d  = S_DONE;
        end else if (!p_in_rxd_wr && (tmo_q == TMO_LAST)) begin
          done_d   = 1'b1;
          result_d = trn_result(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    p_out_txd = 8'h00;
    if (txd_rdy_q) begin
      if (tx_idx_q == IW'(0)) begin
        p_out_txd = adr_q;
      end else if (tx_idx_q == IW'(1)) begin
        p_out_txd = cmd_q;
      end else begin
        p_out_txd = txbuf_q;
      end
    end
  end

  assign p_out_busy    = busy_q;
  assign p_out_done    = done_q;
  assign p_out_result  = result_q;
  assign p_out_txd_rdy = txd_rdy_q;
  assign p_out_rxlen   = rxlen_q;

endmodule

// File: tb/tb_veresk485_trn.sv
module tb_veresk485_trn;

  localparam int AW    = 4;
  localparam int D     = 16;
  localparam int TMO   = 500;
  localparam int TMO_W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic [7:0]    dev_adr = '0;
  logic [7:0]    dev_cmd = '0;
  logic [AW:0]   txlen = '0;
  logic          txbuf_wr = 1'b0;
  logic [AW-1:0] txbuf_adr = '0;
  logic [7:0]    txbuf_d = '0;
  logic [AW-1:0] rxbuf_adr = '0;
  logic [7:0]    rxbuf_q;
  logic [AW:0]   rxlen;
  logic          busy;
  logic          done;
  logic [2:0]    result;
  logic          txd_rdy;
  logic [7:0]    txd;
  logic          txd_rd = 1'b0;
  logic [7:0]    rxd = '0;
  logic          rxd_wr = 1'b0;
  logic [2:0]    status = '0;

  logic [7:0] exp_q[$];      // expected bytes on p_out_txd
  logic [7:0] exp_rx_q[$];   // expected RX buffer contents
  logic [7:0] tb_txbuf [D];  // model of the TX buffer

  int n_checks = 0;
  int n_fail   = 0;

  veresk485_trn #(.G_BUF_AW(AW), .G_TMO(TMO), .G_TMO_W(TMO_W)) dut (
    .p_in_clk       (clk),
    .p_in_rst       (rst),
    .p_in_req       (req),
    .p_in_dev_adr   (dev_adr),
    .p_in_dev_cmd   (dev_cmd),
    .p_in_txlen     (txlen),
    .p_in_txbuf_wr  (txbuf_wr),
    .p_in_txbuf_adr (txbuf_adr),
    .p_in_txbuf_d   (txbuf_d),
    .p_in_rxbuf_adr (rxbuf_adr),
    .p_out_rxbuf_q  (rxbuf_q),
    .p_out_rxlen    (rxlen),
    .p_out_busy     (busy),
    .p_out_done     (done),
    .p_out_result   (result),
    .p_out_txd_rdy  (txd_rdy),
    .p_out_txd      (txd),
    .p_in_txd_rd    (txd_rd),
    .p_in_rxd       (rxd),
    .p_in_rxd_wr    (rxd_wr),
    .p_in_status    (status)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // Driver tasks: entered and left just after a falling edge.
  task automatic wr_txbuf(input logic [AW-1:0] a, input logic [7:0] d, input bit model);
    txbuf_wr = 1'b1; txbuf_adr = a; txbuf_d = d;
    @(negedge clk);
    txbuf_wr = 1'b0;
    if (model) tb_txbuf[a] = d;
  endtask

  task automatic start_trn(input logic [7:0] a, input logic [7:0] c, input int len);
    int n;
    n = (len > D) ? D : len;
    dev_adr = a; dev_cmd = c; txlen = (AW+1)'(len);
    exp_q.delete();
    exp_q.push_back(a);
    exp_q.push_back(c);
    for (int i = 0; i < n; i++) exp_q.push_back(tb_txbuf[i]);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic collect_tx(input int n, input string name);
    int w;
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!txd_rdy && w < 20) begin
        @(negedge clk);
        w++;
      end
      n_checks++;
      if (!txd_rdy) begin
        n_fail++;
        $display("FAIL %s_txd_rdy byte %0d: txd_rdy=%0b required 1", name, i, txd_rdy);
        return;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      n_checks++;
      if (txd !== e) begin
        n_fail++;
        $display("FAIL %s_txd byte %0d: got %02h required %02h", name, i, txd, e);
      end
      txd_rd = 1'b1;
      @(negedge clk);
      txd_rd = 1'b0;
    end
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic [2:0] st);
    rxd = b; rxd_wr = 1'b1; status = st;
    @(negedge clk);
    rxd_wr = 1'b0;
  endtask

  // Waits for done (bounded), then checks it is a single pulse and busy drops.
  task automatic wait_done(input int max, input string name, output int cyc);
    cyc = 0;
    while (!done && cyc < max) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_done: no done within %0d cycles", name, max);
    end
    status = 3'd0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_after_done: done=%0b busy=%0b required 0 0", name, done, busy);
    end
  endtask

  // Scoreboard drain: RX length and contents against expected queue.
  task automatic check_rx(input string name);
    n_checks++;
    if (rxlen !== (AW+1)'(exp_rx_q.size())) begin
      n_fail++;
      $display("FAIL %s_rxlen: got %0d required %0d", name, rxlen, exp_rx_q.size());
    end
    for (int i = 0; exp_rx_q.size() > 0; i++) begin
      logic [7:0] e;
      e = exp_rx_q.pop_front();
      rxbuf_adr = AW'(i);
      @(negedge clk);
      n_checks++;
      if (rxbuf_q !== e) begin
        n_fail++;
        $display("FAIL %s_rxbuf[%0d]: got %02h required %02h", name, i, rxbuf_q, e);
      end
    end
  endtask

  task automatic check_result(input logic [2:0] e, input string name);
    n_checks++;
    if (result !== e) begin
      n_fail++;
      $display("FAIL %s_result: got %0d required %0d", name, result, e);
    end
  endtask

  task automatic check_tx_end(input string name);
    n_checks++;
    if (txd_rdy !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_tx_end: txd_rdy=%0b busy=%0b required 0 1", name, txd_rdy, busy);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, txd_rdy} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: busy=%0b done=%0b txd_rdy=%0b required 0 0 0", busy, done, txd_rdy);
    end
    n_checks++;
    if (result !== 3'd0 || rxlen !== '0) begin
      n_fail++;
      $display("FAIL reset_result: result=%0d rxlen=%0d required 0 0", result, rxlen);
    end
    n_checks++;
    if (txd !== 8'h00 || rxbuf_q !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: txd=%02h rxbuf_q=%02h required 00 00", txd, rxbuf_q);
    end
  endtask

  task automatic test_basic();
    int cyc;
    wr_txbuf(0, 8'hA0, 1);
    wr_txbuf(1, 8'hA1, 1);
    start_trn(8'h21, 8'h05, 2);
    collect_tx(4, "basic");
    check_tx_end("basic");
    rx_byte(8'h21, 3'd0);
    rx_byte(8'h05, 3'd0);
    rx_byte(8'h55, 3'd0);
    exp_rx_q.push_back(8'h55);
    status = 3'd1;
    wait_done(50, "basic", cyc);
    check_result(3'd0, "basic");
    check_rx("basic");
  endtask

  task automatic test_timeout();
    int cyc;
    start_trn(8'h21, 8'h05, 0);
    collect_tx(2, "tmo");
    check_tx_end("tmo");
    wait_done(TMO + 20, "tmo", cyc);
    n_checks++;
    if (cyc != TMO) begin
      n_fail++;
      $display("FAIL tmo_latency: done after %0d cycles required %0d", cyc, TMO);
    end
    check_result(3'd2, "tmo");
    // Restart straight away; byte and status arrive in the same cycle.
    wr_txbuf(0, 8'h3A, 1);
    start_trn(8'h21, 8'h05, 1);
    n_checks++;
    if (txd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_restart_rdy: txd_rdy=%0b required 1", txd_rdy);
    end
    collect_tx(3, "tmo_restart");
    check_tx_end("tmo_restart");
    rx_byte(8'h21, 3'd0);
    rx_byte(8'h05, 3'd0);
    rx_byte(8'h66, 3'd1);
    exp_rx_q.push_back(8'h66);
    wait_done(50, "tmo_restart", cyc);
    check_result(3'd0, "tmo_restart");
    check_rx("tmo_restart");
  endtask

  task automatic test_errors();
    int cyc;
    start_trn(8'h21, 8'h05, 0);
    collect_tx(2, "hdr");
    rx_byte(8'h21, 3'd0);
    rx_byte(8'h06, 3'd0);
    status = 3'd1;
    wait_done(50, "hdr", cyc);
    check_result(3'd3, "hdr");
    check_rx("hdr");

    start_trn(8'h21, 8'h05, 0);
    collect_tx(2, "short");
    rx_byte(8'h21, 3'd0);
    status = 3'd1;
    wait_done(50, "short", cyc);
    check_result(3'd5, "short");
    check_rx("short");

    start_trn(8'h21, 8'h05, 0);
    collect_tx(2, "parity");
    rx_byte(8'h21, 3'd0);
    rx_byte(8'h05, 3'd0);
    rx_byte(8'h77, 3'd0);
    exp_rx_q.push_back(8'h77);
    status = 3'd2;
    wait_done(50, "parity", cyc);
    check_result(3'd1, "parity");
    check_rx("parity");
  endtask

  task automatic test_ovf();
    int cyc;
    start_trn(8'h3C, 8'h7E, 0);
    collect_tx(2, "ovf");
    rx_byte(8'h3C, 3'd0);
    rx_byte(8'h7E, 3'd0);
    for (int k = 0; k < D + 3; k++) begin
      rx_byte(8'h80 + 8'(k), 3'd0);
      if (k < D) exp_rx_q.push_back(8'h80 + 8'(k));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    status = 3'd1;
    wait_done(50, "ovf", cyc);
    check_result(3'd4, "ovf");
    check_rx("ovf");
  endtask

  task automatic test_busy_ignore();
    int cyc;
    int extra;
    wr_txbuf(0, 8'h11, 1);
    wr_txbuf(1, 8'h22, 1);
    wr_txbuf(2, 8'h33, 1);
    start_trn(8'h44, 8'h12, 3);
    wr_txbuf(0, 8'hEE, 0);
    dev_adr = 8'h99; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    collect_tx(5, "busy");
    check_tx_end("busy");
    rx_byte(8'h44, 3'd0);
    req = 1'b1;
    rx_byte(8'h12, 3'd0);
    req = 1'b0;
    status = 3'd1;
    wait_done(50, "busy", cyc);
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_checks++;
    if (extra != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_single_done: extra dones=%0d busy=%0b required 0 0", extra, busy);
    end
    check_result(3'd0, "busy");
    // Buffer must still hold 11 22 33.
    start_trn(8'h44, 8'h12, 3);
    collect_tx(5, "busy_rerun");
    rx_byte(8'h44, 3'd0);
    rx_byte(8'h12, 3'd0);
    status = 3'd1;
    wait_done(50, "busy_rerun", cyc);
    check_result(3'd0, "busy_rerun");
  endtask

  task automatic test_reset_mid();
    int cyc;
    start_trn(8'h21, 8'h05, 2);
    collect_tx(2, "rstmid");
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({txd_rdy, busy, done} !== 3'b000 || txd !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_outputs: txd_rdy=%0b busy=%0b done=%0b txd=%02h required 0 0 0 00",
               txd_rdy, busy, done, txd);
    end
    rst = 1'b0;
    @(negedge clk);
    wr_txbuf(0, 8'h5C, 1);
    wr_txbuf(1, 8'hC5, 1);
    start_trn(8'h21, 8'h05, 2);
    collect_tx(4, "rstmid_after");
    check_tx_end("rstmid_after");
    rx_byte(8'h21, 3'd0);
    rx_byte(8'h05, 3'd0);
    rx_byte(8'hAB, 3'd0);
    rx_byte(8'hCD, 3'd0);
    exp_rx_q.push_back(8'hAB);
    exp_rx_q.push_back(8'hCD);
    status = 3'd1;
    wait_done(50, "rstmid_after", cyc);
    check_result(3'd0, "rstmid_after");
    check_rx("rstmid_after");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_errors();
    test_ovf();
    test_busy_ignore();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/veresk485_trn.md
Name: veresk485_trn

Overview:
- Transaction controller sitting directly upstream of the RS-485 Manchester master: the host loads a request, the block streams DEV_ADR, DEV_CMD and payload bytes to the master's byte interface, then collects the answer bytes.
- It checks the echoed header, enforces a response timeout and reports one result code per transaction.
- Host side is a TX byte buffer, an RX byte buffer and a start/done handshake.

Parameters:
- G_BUF_AW, 4, address width of the TX and RX payload buffers; depth D = 2**G_BUF_AW.
- G_TMO, 32000, response timeout in p_in_clk cycles (1 ms at 32 MHz).
- G_TMO_W, 16, timeout counter width; must satisfy 2**G_TMO_W > G_TMO.

Ports:
- p_in_clk  in  1  system clock, 32 MHz
- p_in_rst  in  1  asynchronous, active-high reset
- p_in_req  in  1  start pulse (1 cycle)
- p_in_dev_adr  in  8  device address, sampled at start
- p_in_dev_cmd  in  8  device command, sampled at start
- p_in_txlen  in  G_BUF_AW+1  payload byte count, 0..D, sampled at start
- p_in_txbuf_wr  in  1  TX buffer write strobe
- p_in_txbuf_adr  in  G_BUF_AW  TX buffer write address
- p_in_txbuf_d  in  8  TX buffer write data
- p_in_rxbuf_adr  in  G_BUF_AW  RX buffer read address
- p_out_rxbuf_q  out  8  RX buffer read data, registered, 1-cycle latency
- p_out_rxlen  out  G_BUF_AW+1  received payload bytes stored
- p_out_busy  out  1  transaction in progress
- p_out_done  out  1  1-cycle pulse at end of transaction
- p_out_result  out  3  result code, valid from p_out_done until next start
- p_out_txd_rdy  out  1  to master: byte available
- p_out_txd  out  8  to master: current byte
- p_in_txd_rd  in  1  from master: current byte consumed (1-cycle pulse)
- p_in_rxd  in  8  from master: received byte
- p_in_rxd_wr  in  1  from master: received byte strobe
- p_in_status  in  3  from master: 0 = busy/cleared, 1 = RX OK, 2 = RX parity error

Behaviour:
- Reset values:
  - all outputs 0; FSM in S_IDLE.
  - Buffer contents are undefined after reset.
- FSM states: S_IDLE, S_TX, S_RESP, S_DONE.
- S_IDLE:
  - p_in_req=1 latches adr, cmd and len (len clipped to D if larger).
  - Clears tx_idx, rx_cnt, flags and p_out_rxlen.
  - Sets busy=1 and txd_rdy=1, then goes to S_TX.
  - p_in_req while busy is ignored.
- TX buffer writes are accepted only in S_IDLE; writes while busy are ignored.
- S_TX:
  - p_out_txd = adr (tx_idx=0), cmd (tx_idx=1), txbuf[tx_idx-2] otherwise.
  - p_out_txd is held stable until p_in_txd_rd; on txd_rd, tx_idx increments and the next byte is presented on the next cycle.
  - On txd_rd with tx_idx = len+1 (last byte): txd_rdy<=0 on the next cycle, timeout counter cleared, go to S_RESP.
  - txd_rdy must be low before the master's end-of-byte check, which falls 2 bit-quarters after txd_rd.
- S_RESP:
  - Each p_in_rxd_wr increments rx_cnt (saturating) and restarts the timeout counter.
  - rx_cnt=0: compare to adr; mismatch sets hdr_err.
  - rx_cnt=1: compare to cmd; mismatch sets hdr_err.
  - rx_cnt>=2: write rxbuf[rx_cnt-2] while rx_cnt-2 < D, otherwise set ovf and drop the byte.
  - p_out_rxlen = min(rx_cnt-2, D), floored at 0.
  - Nonzero p_in_status ends the transaction: go to S_DONE.
  - Timeout counter reaching G_TMO with status still 0 also goes to S_DONE, as a timeout.
  - If rxd_wr and status are nonzero in the same cycle, the byte is processed first and then status is evaluated.
- Result code, priority high to low:
  - 2 = TIMEOUT
  - 1 = PARITY (status=2)
  - 5 = SHORT (rx_cnt<2)
  - 3 = HDR (hdr_err)
  - 4 = OVF (ovf)
  - 0 = OK
- S_DONE: p_out_done=1 for 1 cycle, result registered, busy<=0, go to S_IDLE.
- After a timeout the master is left in its RX-wait state. The next start raises txd_rdy, which returns the master to TX; no extra action is required.
- The status input is sampled only in S_RESP. The master clears status when it accepts txd_rdy, so stale status from a previous transaction is never seen.
- Reset asserted mid-transaction aborts immediately.
  - All outputs return to reset values; txd_rdy drops.
  - No p_out_done is issued.

Decomposition:
- Include file veresk485_pkg.vh holds:
  - result codes TRN_OK=0, TRN_PARITY=1, TRN_TIMEOUT=2, TRN_HDR=3, TRN_OVF=4, TRN_SHORT=5;
  - master status codes ST_RX_OK=1, ST_RX_ERR=2.
- One sub-module veresk485_bytebuf: simple dual-port RAM, 8 x 2**AW, sync write, registered read, instantiated twice (TX and RX).

Test Plan:
- adr=0x21, cmd=0x05, len=2, txbuf={0xA0,0xA1}; model answers {0x21,0x05,0x55}, status=1 -> txd sequence 21,05,A0,A1; txd_rdy low after 4th txd_rd; done, result=0, rxlen=1, rxbuf[0]=0x55.
- len=0, model never answers -> done exactly G_TMO cycles after last txd_rd, result=2; immediate new req -> txd_rdy=1 and transaction completes OK.
- Answer {0x21,0x06} then status=1 -> result=3; answer {0x21} then status=1 -> result=5; status=2 after 3 bytes -> result=1.
- Answer header + D+3 payload bytes, status=1 -> result=4, rxlen=D, rxbuf[D-1] = D-th payload byte, no buffer wrap.
- p_in_req and txbuf writes during busy -> ignored, buffer contents unchanged, single done.
- Assert p_in_rst during S_TX after 2nd txd_rd -> txd_rdy, busy and done=0 next cycle; subsequent transaction OK.
